// File: rtl/frs_pkg.sv
// Shared types and constants for the file read sequencer.
package frs_pkg;
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  localparam int unsigned MAX_FILESIZE_DEF = 100000000;
  localparam int unsigned IDLE_COUNT       = MAX_FILESIZE_DEF;
  localparam int unsigned BUF_DEPTH        = 2;
endpackage

// File: rtl/frs_skid_fifo.sv
// Two-entry skid FIFO between the RAM read port and the output stream.
module frs_skid_fifo
  import frs_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);
  logic [BUF_DEPTH-1:0][W-1:0] mem;
  logic                        wp, rp;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  // Head comes straight from storage registers; zero when empty.
  assign dout = (occ != 2'd0) ? mem[rp] : '0;
endmodule

// File: rtl/file_read_sequencer.sv
// Reads a file of N words from buffer RAM and streams it out with valid/ready.
module file_read_sequencer
  import frs_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_W-1:0] MAX_FILESIZE = ADDR_W'(IDLE_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic [ADDR_W-1:0] filesize,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t            state, nxt;
  logic [ADDR_W-1:0] len_r, rd_idx, acc_r;
  logic              rd_pend, rd_last_pend, err_r;
  logic [1:0]        occ;
  logic [DATA_W:0]   head;
  logic [2:0]        used;
  logic              xfer, size_ok, start_ok, issue, last_issue;

  assign xfer     = out_valid && out_ready;
  assign size_ok  = (filesize != '0) && (filesize <= MAX_FILESIZE);
  assign start_ok = enable && start && size_ok && (state == S_IDLE);

  // A word popped this cycle frees its slot in time for a read issued now.
  assign used       = 3'(occ) + 3'(rd_pend) - 3'(xfer);
  assign issue      = enable && (state == S_STREAM) && (rd_idx < len_r) &&
                      (used < 3'(BUF_DEPTH));
  assign last_issue = issue && (rd_idx == len_r - 1'b1);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start_ok) nxt = S_STREAM;
      S_STREAM: if (last_issue) nxt = S_DRAIN;
      S_DRAIN:  if (xfer && out_last) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    if (!enable) nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      len_r        <= '0;
      rd_idx       <= '0;
      acc_r        <= '0;
      rd_pend      <= 1'b0;
      rd_last_pend <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state        <= nxt;
      rd_pend      <= issue;
      rd_last_pend <= last_issue;
      err_r        <= enable && start && (state == S_IDLE) && !size_ok;
      if (start_ok) len_r <= filesize;
      if (state == S_IDLE || nxt == S_IDLE) begin
        rd_idx <= '0;
        acc_r  <= '0;
      end else begin
        if (issue) rd_idx <= rd_idx + 1'b1;
        if (xfer)  acc_r  <= acc_r + 1'b1;
      end
    end
  end

  // Data returning after an abort is dropped by gating push with enable.
  frs_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(!enable),
    .push (rd_pend && enable),
    .pop  (xfer),
    .din  ({rd_last_pend, mem_rdata}),
    .dout (head),
    .occ  (occ)
  );

  assign mem_rd_en = issue;
  assign mem_addr  = BASE_ADDR + rd_idx;
  assign out_valid = (occ != 2'd0);
  assign out_data  = head[DATA_W-1:0];
  assign out_last  = out_valid && head[DATA_W];
  assign busy      = (state != S_IDLE);
  assign done      = !busy;
  assign err       = err_r;
  assign count     = busy ? acc_r + ADDR_W'(xfer) : MAX_FILESIZE;
endmodule

// File: tb/tb_file_read_sequencer.sv
// Directed bench with a transaction-level stream model checked every cycle.
module tb_file_read_sequencer;
  localparam logic [31:0] BASE = 32'h40;
  localparam logic [31:0] MAXF = 32'd100000000;

  logic        clk = 1'b0;
  logic        rst, enable, start, out_ready;
  logic [31:0] filesize;
  logic        mem_rd_en, out_valid, out_last, busy, done, err;
  logic [31:0] mem_addr, mem_rdata, out_data, count;

  int errors = 0;
  int checks = 0;

  // stream model state
  bit          mon_on = 0;
  bit          m_act = 0;
  int unsigned m_len, m_rd, m_acc;
  int unsigned rd_cnt = 0, xfer_cnt = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data;

  always #5 clk = ~clk;

  file_read_sequencer #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .filesize(filesize),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .count(count), .busy(busy), .done(done), .err(err)
  );

  // Buffer RAM: word k holds 0xA0+k, one cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= 32'hA0 + (mem_addr - BASE);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon();
    bit was, xf;
    if (!mon_on) return;
    was = m_act;
    xf  = out_valid && out_ready;
    if (!m_act) begin
      check("idle_busy", busy, 0);
      check("idle_done", done, 1);
      check("idle_count", count, MAXF);
      check("idle_valid", out_valid, 0);
      check("idle_rd", mem_rd_en, 0);
    end else begin
      check("act_busy", busy, 1);
      check("act_done", done, 0);
      if (mem_rd_en) begin
        check("rd_addr", mem_addr, BASE + m_rd);
        check("rd_range", m_rd < m_len, 1);
        m_rd++;
        rd_cnt++;
      end
      check("credit", (m_rd - m_acc - xf) <= 2, 1);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
      end
      if (out_valid) begin
        check("data", out_data, 32'hA0 + m_acc);
        check("last", out_last, m_acc == m_len - 1);
      end
      check("count", count, m_acc + xf);
      if (xf) begin
        xfer_cnt++;
        m_acc++;
        if (m_acc == m_len) m_act = 0;
      end
    end
    prev_stall = m_act && out_valid && !out_ready && enable && !rst;
    prev_data  = out_data;
    if (rst || !enable) m_act = 0;
    else if (!was && start && filesize != 0 && filesize <= MAXF) begin
      m_act = 1; m_len = filesize; m_rd = 0; m_acc = 0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int n);
    for (int i = 0; i < n && busy; i++) cyc();
    check(name, busy, 0);
  endtask

  task automatic pulse_start(input logic [31:0] fs);
    filesize = fs; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int unsigned r0, x0;
    logic bp [4];
    bp = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1; enable = 0; start = 0; filesize = 0; out_ready = 1;
    cyc(); cyc();
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, BASE);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_count", count, MAXF);
    check("rst_busy", busy, 0);
    check("rst_done", done, 1);
    check("rst_err", err, 0);
    mon_on = 1; rst = 0; enable = 1;
    cyc();

    // nominal, filesize=4
    pulse_start(4);
    check("nom_c1_rd", mem_rd_en, 1);
    check("nom_c1_addr", mem_addr, BASE);
    check("nom_c1_done", done, 0);
    check("nom_c1_valid", out_valid, 0);
    cyc();
    check("nom_c2_addr", mem_addr, BASE + 1);
    cyc();
    check("nom_c3_valid", out_valid, 1);
    check("nom_c3_data", out_data, 32'hA0);
    check("nom_c3_count", count, 1);
    check("nom_c3_addr", mem_addr, BASE + 2);
    cyc();
    check("nom_c4_data", out_data, 32'hA1);
    cyc();
    check("nom_c5_data", out_data, 32'hA2);
    check("nom_c5_last", out_last, 0);
    cyc();
    check("nom_c6_data", out_data, 32'hA3);
    check("nom_c6_last", out_last, 1);
    check("nom_c6_count", count, 4);
    check("nom_c6_rd", mem_rd_en, 0);
    cyc();
    check("nom_c7_done", done, 1);
    check("nom_c7_count", count, MAXF);

    // backpressure, filesize=6
    x0 = xfer_cnt;
    pulse_start(6);
    for (int i = 0; i < 10 && !out_valid; i++) cyc();
    check("bp_first_valid", out_valid, 1);
    for (int i = 0; i < 200 && busy; i++) begin
      out_ready = (i < 4) ? bp[i] : 1'($urandom_range(0, 1));
      cyc();
    end
    check("bp_idle", busy, 0);
    check("bp_words", xfer_cnt - x0, 6);
    out_ready = 1;
    cyc();

    // single word
    r0 = rd_cnt; x0 = xfer_cnt;
    pulse_start(1);
    check("one_rd", mem_rd_en, 1);
    cyc(); cyc();
    check("one_valid", out_valid, 1);
    check("one_last", out_last, 1);
    check("one_data", out_data, 32'hA0);
    cyc();
    check("one_done", done, 1);
    check("one_rds", rd_cnt - r0, 1);
    check("one_words", xfer_cnt - x0, 1);

    // illegal sizes
    r0 = rd_cnt;
    pulse_start(0);
    check("ill0_err", err, 1);
    check("ill0_done", done, 1);
    cyc();
    check("ill0_err_clr", err, 0);
    pulse_start(MAXF + 1);
    check("illbig_err", err, 1);
    check("illbig_done", done, 1);
    cyc(); cyc();
    check("ill_no_rd", rd_cnt - r0, 0);

    // abort after 3 words, then clean restart
    x0 = xfer_cnt;
    pulse_start(10);
    for (int i = 0; i < 50 && (xfer_cnt - x0) < 3; i++) cyc();
    check("abort_reach3", (xfer_cnt - x0) >= 3, 1);
    enable = 0;
    cyc();
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_count", count, MAXF);
    check("abort_done", done, 1);
    enable = 1;
    cyc();
    x0 = xfer_cnt;
    pulse_start(2);
    check("restart_rd", mem_rd_en, 1);
    check("restart_addr", mem_addr, BASE);
    wait_idle("restart_idle", 20);
    check("restart_words", xfer_cnt - x0, 2);

    // reset mid-stream, start while busy ignored
    pulse_start(8);
    cyc();
    filesize = 3; start = 1;
    cyc();
    check("busy_start_ign", busy, 1);
    start = 0; rst = 1;
    cyc();
    check("mrst_rd_en", mem_rd_en, 0);
    check("mrst_addr", mem_addr, BASE);
    check("mrst_valid", out_valid, 0);
    check("mrst_last", out_last, 0);
    check("mrst_data", out_data, 0);
    check("mrst_count", count, MAXF);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 1);
    check("mrst_err", err, 0);
    rst = 0;
    cyc(); cyc();
    check("post_rst_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
